mbist_mem_bank_bridge: RTL

//  Wishbone-classic slave to N-SRAM bank bridge; parametrised successor of the single-port MBIST memory wrapper.

---
 rtl/mbist_mem_pkg.sv | 12 +
 rtl/mbist_mem_rd_pipe.sv | 19 +
 rtl/mbist_mem_bank_bridge.sv | 103 ++++++++++
 3 files changed

// File: rtl/mbist_mem_pkg.sv
// mbist_mem_pkg: shared FSM encodings, bank-select width helper and read-latency limits
package mbist_mem_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEM     = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;
  localparam int MIN_RD_LAT = 1;
  localparam int MAX_RD_LAT = 3;
  function automatic int sel_wd(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mbist_mem_rd_pipe.sv
// mbist_mem_rd_pipe: delays the read-start pulse by MEM_RD_LAT-1 cycles into rd_capture
module mbist_mem_rd_pipe #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic rd_capture
);
  if (MEM_RD_LAT == 1) begin : g_direct
    assign rd_capture = start;
  end else begin : g_shift
    logic [MEM_RD_LAT-2:0] sr;
    always_ff @(posedge clk or posedge rst)
      if (rst) sr <= '0;
      else sr <= (sr << 1) | (MEM_RD_LAT-1)'(start);
    assign rd_capture = sr[MEM_RD_LAT-2];
  end
endmodule

// File: rtl/mbist_mem_bank_bridge.sv
// mbist_mem_bank_bridge: wishbone-classic slave to BIST_NO_SRAM SRAM banks with registered controls.
// Define MBIST_MEM_ERR_EN to answer invalid-bank accesses with wb_err_o instead of a dummy ack.
module mbist_mem_bank_bridge
  import mbist_mem_pkg::*;
#(
  parameter int BIST_NO_SRAM = 4,
  parameter int BIST_ADDR_WD = 10,
  parameter int BIST_DATA_WD = 32,
  parameter int MEM_RD_LAT   = 1,
  localparam int SEL_WD  = sel_wd(BIST_NO_SRAM),
  localparam int MASK_WD = BIST_DATA_WD / 8
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_i,
  input  logic                               wb_cyc_i,
  input  logic                               wb_stb_i,
  input  logic                               wb_we_i,
  input  logic [SEL_WD+BIST_ADDR_WD-1:0]     wb_adr_i,
  input  logic [BIST_DATA_WD-1:0]            wb_dat_i,
  input  logic [MASK_WD-1:0]                 wb_sel_i,
  output logic [BIST_DATA_WD-1:0]            wb_dat_o,
  output logic                               wb_ack_o,
  output logic                               wb_err_o,
  output logic                               mem_clk_o,
  output logic [BIST_NO_SRAM-1:0]            mem_cen_o,
  output logic [BIST_NO_SRAM-1:0]            mem_web_o,
  output logic [MASK_WD-1:0]                 mem_mask_o,
  output logic [BIST_ADDR_WD-1:0]            mem_addr_o,
  output logic [BIST_DATA_WD-1:0]            mem_din_o,
  input  logic [BIST_NO_SRAM*BIST_DATA_WD-1:0] mem_dout_i
);
  localparam int PAD_WD = (1 << SEL_WD) * BIST_DATA_WD;
  if (MEM_RD_LAT < MIN_RD_LAT || MEM_RD_LAT > MAX_RD_LAT) begin : g_bad_lat
    $error("MEM_RD_LAT out of range");
  end
  logic [1:0] state;
  logic [SEL_WD-1:0] bank_in, bank_q;
  logic [BIST_NO_SRAM-1:0] bank_oh;
  logic [PAD_WD-1:0] dout_pad;
  logic [BIST_DATA_WD-1:0] rd_data;
  logic we_q, alive, accept, rd_capture;
  assign mem_clk_o = wb_clk_i;
  assign bank_in = wb_adr_i[SEL_WD+BIST_ADDR_WD-1 -: SEL_WD];
  // out-of-range banks shift out of the one-hot and read from the zero padding
  assign bank_oh = BIST_NO_SRAM'(1) << bank_in;
  assign dout_pad = PAD_WD'(mem_dout_i);
  assign rd_data = dout_pad[bank_q*BIST_DATA_WD +: BIST_DATA_WD];
  assign accept = (state == IDLE) && wb_cyc_i && wb_stb_i;
  mbist_mem_rd_pipe #(.MEM_RD_LAT(MEM_RD_LAT)) u_rd_pipe (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .start((state == MEM) && !we_q),
    .rd_capture(rd_capture)
  );
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      mem_cen_o <= '1;
      mem_web_o <= '1;
      mem_mask_o <= '0;
      mem_addr_o <= '0;
      mem_din_o <= '0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      bank_q <= '0;
      we_q <= 1'b0;
      alive <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          bank_q <= bank_in;
          we_q <= wb_we_i;
          alive <= 1'b1;
          mem_mask_o <= wb_sel_i;
          mem_addr_o <= wb_adr_i[BIST_ADDR_WD-1:0];
          mem_din_o <= wb_dat_i;
`ifdef MBIST_MEM_ERR_EN
          if (~|bank_oh) begin
            state <= RESP;
            wb_err_o <= 1'b1;
          end else
`endif
          begin
            state <= MEM;
            mem_cen_o <= ~bank_oh;
            mem_web_o <= wb_we_i ? ~bank_oh : '1;
          end
        end
        MEM, RD_WAIT: begin
          mem_cen_o <= '1;
          mem_web_o <= '1;
          alive <= alive && wb_cyc_i;
          state <= (we_q || rd_capture) ? RESP : RD_WAIT;
          wb_ack_o <= (we_q || rd_capture) && alive && wb_cyc_i;
          if (rd_capture) wb_dat_o <= rd_data;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
